// File: rtl/ct_ciu_snb_age_mtx.sv
// Age matrix for the snoop buffer: tracks which valid entries are older than
// each other entry so an oldest-first selector can pick among requesters.
module ct_ciu_snb_age_mtx #(
  parameter int DEPTH = 24
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst,
  input  logic                   create_req,
  output logic                   create_gnt,
  output logic [DEPTH-1:0]       create_id,
  input  logic [DEPTH-1:0]       pop_vld,
  output logic [DEPTH-1:0]       entry_vld,
  output logic [DEPTH*DEPTH-1:0] age_vect,
  output logic [5:0]             vld_cnt,
  output logic                   full,
  output logic                   empty
);

  logic [DEPTH-1:0] entry_vld_q;
  logic [DEPTH-1:0] entry_vld_d;
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic [DEPTH-1:0] free_id;
  logic [DEPTH-1:0] pop_eff;
  logic [DEPTH-1:0] create_oh;

  function automatic logic [5:0] popcnt(input logic [DEPTH-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  // Status flags come from registered valid bits only.
  always_comb begin
    full    = &entry_vld_q;
    empty   = ~|entry_vld_q;
    vld_cnt = popcnt(entry_vld_q);
  end

  // Lowest-index free entry; scanning downward lets the lowest index win.
  always_comb begin
    free_id = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!entry_vld_q[i]) begin
        free_id    = '0;
        free_id[i] = 1'b1;
      end
    end
  end

  // Grant is suppressed while full and while reset is held.
  always_comb begin
    create_gnt = create_req & ~full & ~cpurst;
    create_oh  = create_gnt ? free_id : '0;
    create_id  = create_oh;
  end

  // Next state: pops of invalid entries are masked out; a new entry sees every
  // surviving valid entry as older, and popped columns are cleared everywhere.
  always_comb begin
    pop_eff     = pop_vld & entry_vld_q;
    entry_vld_d = (entry_vld_q & ~pop_eff) | create_oh;
    for (int i = 0; i < DEPTH; i++) begin
      if (create_oh[i])
        age_d[i] = entry_vld_q & ~pop_eff;
      else if (pop_eff[i] || !entry_vld_q[i])
        age_d[i] = '0;
      else
        age_d[i] = age_q[i] & ~pop_eff;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      entry_vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      entry_vld_q <= entry_vld_d;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end
  end

  // Flatten the per-entry age rows onto the output bus.
  always_comb begin
    entry_vld = entry_vld_q;
    for (int i = 0; i < DEPTH; i++) age_vect[i*DEPTH +: DEPTH] = age_q[i];
  end

endmodule

// File: doc/ct_ciu_snb_age_mtx.md
CT_CIU_SNB_AGE_MTX -- requirements
Module: ct_ciu_snb_age_mtx

Interface
REQ-001 Parameter: DEPTH, default 24, number of tracked entries; legal range 2..32.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 forever_cpuclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 cpurst  input  1  asynchronous, active-high reset.
REQ-005 create_req  input  1  request to allocate one entry this cycle.
REQ-006 create_gnt  output  1  allocation accepted this cycle; combinational from create_req and registered state.
REQ-007 create_id  output  DEPTH  one-hot index of the entry granted; all-zero when create_gnt=0.
REQ-008 pop_vld  input  DEPTH  entries released this cycle; multi-hot allowed.
REQ-009 entry_vld  output  DEPTH  registered valid bit per entry.
REQ-010 age_vect  output  DEPTH*DEPTH  entry i vector at bits [i*DEPTH +: DEPTH]; bit j=1 means entry j is valid and older than entry i.
REQ-011 vld_cnt  output  6  number of valid entries.
REQ-012 full  output  1  all DEPTH entries valid.
REQ-013 empty  output  1  no entry valid.

Function
REQ-014 The block SHALL maintain the age state consumed by the snoop-buffer oldest-first selector, which picks entry i when req[i] and (req AND age_vect_i) is zero.
REQ-015 create_gnt SHALL equal create_req AND NOT full, with full evaluated from registered entry_vld only.
REQ-016 create_id SHALL select the lowest-index entry with entry_vld=0.
REQ-017 On grant, at the next edge the block SHALL set entry_vld[create_id] and load its age vector with entry_vld AND NOT pop_vld, both sampled in the grant cycle.
REQ-018 A newly created entry SHALL never mark itself older: bit i of age_vect_i SHALL always be 0.
REQ-019 On pop_vld[j]=1 with entry_vld[j]=1, at the next edge the block SHALL clear entry_vld[j], clear all of age_vect_j, and clear column j (bit j) in every other entry's age vector.
REQ-020 pop_vld bits for invalid entries SHALL be ignored and SHALL NOT change any state.
REQ-021 A same-cycle create and pop SHALL both take effect; an entry freed by pop SHALL NOT be granted in that same cycle.
REQ-022 A grant while the existing entries are popped in the same cycle SHALL produce an all-zero age vector for the new entry.
REQ-023 Invariant: for valid i≠j, exactly one of age_vect_i[j] and age_vect_j[i] SHALL be 1; for invalid entries all age bits SHALL be 0.
REQ-024 vld_cnt, full and empty SHALL be derived combinationally from registered entry_vld; vld_cnt SHALL be zero-extended to 6 bits.
REQ-025 Latency: create and pop SHALL become visible on entry_vld and age_vect exactly one cycle after the request cycle.
REQ-026 create_req while full SHALL give create_gnt=0, create_id=0, and SHALL cause no state change.

Reset
REQ-027 Assertion of cpurst SHALL immediately clear entry_vld and all age vectors: vld_cnt=0, empty=1, full=0.
REQ-028 create_gnt and create_id SHALL be 0 while cpurst is asserted, regardless of create_req.
REQ-029 On reset assertion mid-operation, in-flight creates and pops SHALL be discarded.
REQ-030 After reset deassertion, the first grant SHALL be to entry 0.

Verification
REQ-031 Scenario: after reset, 3 back-to-back create_req -> create_id = 0x1, 0x2, 0x4; age_vect_2 = 0x3, age_vect_1 = 0x1, age_vect_0 = 0; vld_cnt = 3.
REQ-032 Scenario: from that state, pop_vld = 0x1 -> next cycle entry_vld = 0x6, age_vect_1 = 0, age_vect_2 = 0x2; then create_req -> create_id = 0x1, new age_vect_0 = 0x6.
REQ-033 Scenario: fill all 24 entries, then create_req -> create_gnt = 0, full = 1, vld_cnt = 24; same-cycle pop_vld = 0x800000 -> no grant that cycle; grant create_id = 0x800000 in the following cycle.
REQ-034 Scenario: entries 0 and 1 valid; same cycle create_req with pop_vld = 0x3 -> entry 2 granted, age_vect_2 = 0, entry_vld = 0x4.
REQ-035 Scenario: pop_vld of an invalid entry, and cpurst asserted mid-stream -> no state change for the invalid pop; after reset all outputs zero with empty = 1.
REQ-036 Scenario: random create/pop for 10k cycles -> the REQ-023 invariant holds every cycle, and a reference selector on age_vect always picks the oldest requester.
